ervp_design_info_reader: RTL and testbench



---
 rtl/ervp_design_info_reader_pkg.sv | 34 +++
 rtl/ervp_design_info_reader_if.sv | 34 +++
 rtl/ervp_word_byte_unpacker.sv | 80 ++++++++
 rtl/ervp_design_info_reader.sv | 155 +++++++++++++++
 tb/tb_ervp_design_info_reader.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ervp_design_info_reader_pkg.sv
`default_nettype none
// ============================================================================
// ervp_design_info_reader_pkg : shared types and width helpers for the reader
// Rev 1.0
// ============================================================================
package ervp_design_info_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_EMIT   = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  // String order on the bus: the first character sits in the top byte.
  localparam int FIRST_CHAR_MSB = 31;

  function automatic int num_words_width(input int max_words);
    return $clog2(max_words + 1);
  endfunction

  function automatic int char_count_width(input int max_words);
    return $clog2(4 * max_words + 1);
  endfunction

  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [31:0] shifted;
    shifted = word << {idx, 3'b000};
    return shifted[FIRST_CHAR_MSB -: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ervp_design_info_reader_if.sv
`default_nettype none
// ============================================================================
// ervp_design_info_reader_if : APB read bus plus character stream
// Rev 1.0
// ============================================================================
interface ervp_design_info_reader_if #(
  parameter int BW_ADDR = 32
) ();
  logic               psel;
  logic               penable;
  logic               pwrite;
  logic [BW_ADDR-1:0] paddr;
  logic [31:0]        prdata;
  logic               pready;
  logic               pslverr;
  logic               char_valid;
  logic [7:0]         char_data;
  logic               char_ready;

  modport master (
    output psel, penable, pwrite, paddr,
    input  prdata, pready, pslverr,
    output char_valid, char_data,
    input  char_ready
  );

  modport slave (
    input  psel, penable, pwrite, paddr,
    output prdata, pready, pslverr,
    input  char_valid, char_data,
    output char_ready
  );
endinterface
`default_nettype wire

// File: rtl/ervp_word_byte_unpacker.sv
`default_nettype none
// ============================================================================
// ervp_word_byte_unpacker : splits a 32-bit word into a valid/ready byte stream
// Rev 1.0
// ============================================================================
module ervp_word_byte_unpacker
  import ervp_design_info_reader_pkg::*;
#(
  parameter bit STOP_AT_NUL = 1'b1
) (
  input  logic        clk,
  input  logic        rstnn,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] load_word,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        accept,
  output logic        word_done,
  output logic        nul_found
);

  logic [31:0] r_word;
  logic [1:0]  r_idx;
  logic        r_loaded;
  logic        r_nul;
  logic [1:0]  w_pidx;
  logic [7:0]  w_pbyte;
  logic        w_pnul;

  assign accept    = char_valid & char_ready;
  assign word_done = accept & (r_idx == 2'd3);
  assign nul_found = r_nul;

  // First presentation uses the current index; after a handshake the next one.
  assign w_pidx  = char_valid ? (r_idx + 2'd1) : r_idx;
  assign w_pbyte = word_byte(r_word, w_pidx);
  assign w_pnul  = STOP_AT_NUL && (w_pbyte == 8'h00);

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_word     <= '0;
      r_idx      <= '0;
      r_loaded   <= 1'b0;
      r_nul      <= 1'b0;
      char_valid <= 1'b0;
      char_data  <= '0;
    end else if (flush) begin
      r_idx      <= '0;
      r_loaded   <= 1'b0;
      r_nul      <= 1'b0;
      char_valid <= 1'b0;
    end else if (load) begin
      r_word     <= load_word;
      r_idx      <= '0;
      r_loaded   <= 1'b1;
      r_nul      <= 1'b0;
      char_valid <= 1'b0;
    end else if (r_loaded && !r_nul) begin
      if (!char_valid || char_ready) begin
        if (char_valid && (r_idx == 2'd3)) begin
          r_loaded   <= 1'b0;
          char_valid <= 1'b0;
        end else begin
          r_idx <= w_pidx;
          if (w_pnul) begin
            r_nul      <= 1'b1;
            char_valid <= 1'b0;
          end else begin
            char_valid <= 1'b1;
            char_data  <= w_pbyte;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ervp_design_info_reader.sv
`default_nettype none
// ============================================================================
// ervp_design_info_reader : APB initiator streaming the design-info string
// Rev 1.0
// ============================================================================
module ervp_design_info_reader
  import ervp_design_info_reader_pkg::*;
#(
  parameter int BW_ADDR        = 32,
  parameter int MAX_WORDS      = 16,
  parameter bit STOP_AT_NUL    = 1'b1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                   clk,
  input  logic                                   rstnn,
  input  logic                                   start,
  input  logic [BW_ADDR-1:0]                     base_addr,
  input  logic [num_words_width(MAX_WORDS)-1:0]  num_words,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   error,
  output logic [char_count_width(MAX_WORDS)-1:0] char_count,
  ervp_design_info_reader_if.master              bus
);

  localparam int NW_W = num_words_width(MAX_WORDS);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [NW_W-1:0] C_MAX_WORDS = NW_W'(MAX_WORDS);
  localparam logic [TO_W-1:0] C_TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  state_t             r_state;
  logic [NW_W-1:0]    r_words_left;
  logic [TO_W-1:0]    r_tcnt;
  logic               r_psel;
  logic               r_penable;
  logic [BW_ADDR-1:0] r_paddr;
  logic               w_load;
  logic               w_flush;
  logic               w_accept;
  logic               w_word_done;
  logic               w_nul_found;

  assign bus.psel    = r_psel;
  assign bus.penable = r_penable;
  assign bus.paddr   = r_paddr;
  assign bus.pwrite  = 1'b0;

  assign w_load  = (r_state == ST_ACCESS) && bus.pready && !bus.pslverr;
  assign w_flush = (r_state == ST_FINISH);

  ervp_word_byte_unpacker #(
    .STOP_AT_NUL (STOP_AT_NUL)
  ) u_unpacker (
    .clk        (clk),
    .rstnn      (rstnn),
    .flush      (w_flush),
    .load       (w_load),
    .load_word  (bus.prdata),
    .char_valid (bus.char_valid),
    .char_data  (bus.char_data),
    .char_ready (bus.char_ready),
    .accept     (w_accept),
    .word_done  (w_word_done),
    .nul_found  (w_nul_found)
  );

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_state      <= ST_IDLE;
      r_words_left <= '0;
      r_tcnt       <= '0;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_paddr      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      char_count   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            busy         <= 1'b1;
            error        <= 1'b0;
            char_count   <= '0;
            r_words_left <= num_words;
            if ((num_words == '0) || (num_words > C_MAX_WORDS)) begin
              error   <= 1'b1;
              done    <= 1'b1;
              r_state <= ST_FINISH;
            end else begin
              r_psel  <= 1'b1;
              r_paddr <= base_addr;
              r_state <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_tcnt    <= '0;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (bus.pready) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            if (bus.pslverr) begin
              error   <= 1'b1;
              done    <= 1'b1;
              r_state <= ST_FINISH;
            end else begin
              r_words_left <= r_words_left - 1'b1;
              r_state      <= ST_EMIT;
            end
          end else if (r_tcnt == C_TO_LAST) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            error     <= 1'b1;
            done      <= 1'b1;
            r_state   <= ST_FINISH;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        ST_EMIT: begin
          if (w_nul_found) begin
            done    <= 1'b1;
            r_state <= ST_FINISH;
          end else if (w_accept) begin
            char_count <= char_count + 1'b1;
            if (w_word_done) begin
              // No prefetch: the next read starts only once this word drained.
              if (r_words_left != '0) begin
                r_psel  <= 1'b1;
                r_paddr <= r_paddr + BW_ADDR'(4);
                r_state <= ST_SETUP;
              end else begin
                done    <= 1'b1;
                r_state <= ST_FINISH;
              end
            end
          end
        end
        ST_FINISH: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ervp_design_info_reader.sv
`default_nettype none
// ============================================================================
// tb_ervp_design_info_reader : directed bench with an APB memory slave model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_ervp_design_info_reader;
  import ervp_design_info_reader_pkg::*;

  localparam int MAX_WORDS = 16;
  localparam int NW_W = num_words_width(MAX_WORDS);
  localparam int CC_W = char_count_width(MAX_WORDS);
  localparam logic [31:0] C_PLATFORM_NAME00 = 32'h0000_0100;

  logic clk = 1'b0;
  logic rstnn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  ervp_design_info_reader_if #(.BW_ADDR(32)) bus_a ();
  ervp_design_info_reader_if #(.BW_ADDR(32)) bus_b ();

  logic            start_a, start_b;
  logic [31:0]     base_a, base_b;
  logic [NW_W-1:0] num_a, num_b;
  logic            busy_a, done_a, error_a, busy_b, done_b, error_b;
  logic [CC_W-1:0] cc_a, cc_b;

  ervp_design_info_reader #(
    .BW_ADDR(32), .MAX_WORDS(MAX_WORDS), .STOP_AT_NUL(1'b1), .TIMEOUT_CYCLES(8)
  ) dut_a (
    .clk(clk), .rstnn(rstnn), .start(start_a), .base_addr(base_a), .num_words(num_a),
    .busy(busy_a), .done(done_a), .error(error_a), .char_count(cc_a), .bus(bus_a)
  );

  ervp_design_info_reader #(
    .BW_ADDR(32), .MAX_WORDS(MAX_WORDS), .STOP_AT_NUL(1'b0), .TIMEOUT_CYCLES(255)
  ) dut_b (
    .clk(clk), .rstnn(rstnn), .start(start_b), .base_addr(base_b), .num_words(num_b),
    .busy(busy_b), .done(done_b), .error(error_b), .char_count(cc_b), .bus(bus_b)
  );

  // Slave model: word memory indexed by paddr[7:2], programmable wait/error.
  logic [31:0] mem [0:63];
  int          wait_req;
  logic        hold_low, ready_toggle, ready_low, tog;
  logic [31:0] err_addr;
  int          acc_cnt_a;

  always @(posedge clk) begin
    acc_cnt_a <= (bus_a.psel && bus_a.penable && !bus_a.pready) ? acc_cnt_a + 1 : 0;
    tog       <= ~tog;
  end

  assign bus_a.pready     = bus_a.psel && bus_a.penable && !hold_low && (acc_cnt_a >= wait_req);
  assign bus_a.prdata     = mem[bus_a.paddr[7:2]];
  assign bus_a.pslverr    = bus_a.pready && (bus_a.paddr == err_addr);
  assign bus_a.char_ready = ready_low ? 1'b0 : (ready_toggle ? tog : 1'b1);
  assign bus_b.pready     = bus_b.psel && bus_b.penable;
  assign bus_b.prdata     = mem[bus_b.paddr[7:2]];
  assign bus_b.pslverr    = 1'b0;
  assign bus_b.char_ready = 1'b1;

  logic [7:0]  got_a[$], got_b[$];
  logic [31:0] addr_a[$], addr_b[$];
  int          done_cnt_a = 0, done_cnt_b = 0, busy_cyc_a = 0, busy_cyc_b = 0, acc_tot_a = 0;
  logic        stalled = 1'b0;
  logic [7:0]  held = 8'h00;

  always @(posedge clk) begin
    if (bus_a.char_valid && bus_a.char_ready) got_a.push_back(bus_a.char_data);
    if (bus_b.char_valid && bus_b.char_ready) got_b.push_back(bus_b.char_data);
    if (bus_a.psel && !bus_a.penable) addr_a.push_back(bus_a.paddr);
    if (bus_b.psel && !bus_b.penable) addr_b.push_back(bus_b.paddr);
    if (done_a) done_cnt_a <= done_cnt_a + 1;
    if (done_b) done_cnt_b <= done_cnt_b + 1;
    if (busy_a) busy_cyc_a <= busy_cyc_a + 1;
    if (busy_b) busy_cyc_b <= busy_cyc_b + 1;
    if (bus_a.psel && bus_a.penable) acc_tot_a <= acc_tot_a + 1;
    stalled <= bus_a.char_valid && !bus_a.char_ready;
    held    <= bus_a.char_data;
  end

  always @(negedge clk) begin
    if (stalled && bus_a.char_valid) check("stall_stable", bus_a.char_data, held);
    if (bus_a.char_valid) check("psel_vs_valid_a", bus_a.psel, 1'b0);
    if (bus_b.char_valid) check("psel_vs_valid_b", bus_b.psel, 1'b0);
  end

  task automatic pulse_start(input bit which, input logic [31:0] base, input logic [NW_W-1:0] n);
    @(negedge clk);
    if (which) begin base_b = base; num_b = n; start_b = 1'b1; end
    else       begin base_a = base; num_a = n; start_a = 1'b1; end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input bit which, input int c0, input string tag);
    int i;
    i = 0;
    while (((which ? done_cnt_b : done_cnt_a) == c0) && (i < 400)) begin
      @(negedge clk);
      i++;
    end
    check(tag, (which ? done_cnt_b : done_cnt_a) - c0, 1);
    @(negedge clk);
  endtask

  task automatic expect_chars(input string tag, input logic [7:0] q[$], input string s);
    check({tag, "_len"}, q.size(), s.len());
    for (int i = 0; i < s.len() && i < q.size(); i++) check({tag, "_chr"}, q[i], s[i]);
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_ctrl"}, {busy_a, done_a, error_a, bus_a.psel, bus_a.penable,
                           bus_a.pwrite, bus_a.char_valid}, 7'b0);
    check({tag, "_paddr"}, bus_a.paddr, 32'h0);
    check({tag, "_data"}, bus_a.char_data, 8'h00);
    check({tag, "_cnt"}, cc_a, 0);
  endtask

  initial begin
    int c0, b0, a0, n0;
    start_a = 1'b0; start_b = 1'b0; base_a = '0; base_b = '0; num_a = '0; num_b = '0;
    wait_req = 0; hold_low = 1'b0; ready_toggle = 1'b0; ready_low = 1'b0; tog = 1'b0;
    err_addr = 32'hFFFF_FFFF; acc_cnt_a = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0]  = 32'h5256_585F; mem[1]  = 32'h424E_4E00;   // "RVX_" "BNN\0"
    mem[8]  = 32'h6162_6364; mem[9]  = 32'h6566_6768;   // "abcd" "efgh"
    mem[16] = 32'h3132_3334; mem[17] = 32'h3536_3738;   // "1234" "5678"
    mem[24] = 32'h4142_4344; mem[25] = 32'h4546_4748;   // "ABCD" "EFGH"

    repeat (3) @(negedge clk);
    check_zero_a("reset");
    rstnn = 1'b1;
    @(negedge clk);

    // Platform name with trailing NULs, zero-wait slave
    got_a.delete(); addr_a.delete(); c0 = done_cnt_a; b0 = busy_cyc_a;
    pulse_start(1'b0, C_PLATFORM_NAME00, 4);
    check("t1_setup", {bus_a.psel, bus_a.penable}, 2'b10);
    @(negedge clk);
    check("t1_access", {bus_a.psel, bus_a.penable}, 2'b11);
    wait_done(1'b0, c0, "t1_done");
    expect_chars("t1", got_a, "RVX_BNN");
    check("t1_cnt", cc_a, 7);
    check("t1_err", error_a, 1'b0);
    check("t1_nwords", addr_a.size(), 2);
    if (addr_a.size() == 2) check("t1_addr1", addr_a[1], 32'h104);
    check("t1_busy_cyc", busy_cyc_a - b0, 15);

    // No NUL stop: two full words
    got_b.delete(); addr_b.delete(); c0 = done_cnt_b; b0 = busy_cyc_b;
    pulse_start(1'b1, 32'h160, 2);
    wait_done(1'b1, c0, "t2_done");
    expect_chars("t2", got_b, "ABCDEFGH");
    check("t2_cnt", cc_b, 8);
    check("t2_nwords", addr_b.size(), 2);
    if (addr_b.size() == 2) begin
      check("t2_addr0", addr_b[0], 32'h160);
      check("t2_addr1", addr_b[1], 32'h164);
    end
    check("t2_busy_cyc", busy_cyc_b - b0, 15);

    // Slow slave, toggling ready, and a stray start while busy
    got_a.delete(); addr_a.delete(); c0 = done_cnt_a;
    wait_req = 3; ready_toggle = 1'b1;
    pulse_start(1'b0, 32'h120, 2);
    repeat (4) @(negedge clk);
    pulse_start(1'b0, C_PLATFORM_NAME00, 1);
    wait_done(1'b0, c0, "t3_done");
    expect_chars("t3", got_a, "abcdefgh");
    check("t3_cnt", cc_a, 8);
    check("t3_nwords", addr_a.size(), 2);
    if (addr_a.size() == 2) check("t3_addr1", addr_a[1], 32'h124);
    repeat (3) @(negedge clk);
    check("t3_no_restart", busy_a, 1'b0);
    wait_req = 0; ready_toggle = 1'b0;

    // Slave error on the second of four words
    got_a.delete(); addr_a.delete(); c0 = done_cnt_a;
    err_addr = 32'h144;
    pulse_start(1'b0, 32'h140, 4);
    wait_done(1'b0, c0, "t4_done");
    expect_chars("t4", got_a, "1234");
    check("t4_err", error_a, 1'b1);
    check("t4_cnt", cc_a, 4);
    err_addr = 32'hFFFF_FFFF;

    // Timeout with pready held low, then a clean request clears error
    got_a.delete(); c0 = done_cnt_a; a0 = acc_tot_a;
    hold_low = 1'b1;
    pulse_start(1'b0, C_PLATFORM_NAME00, 1);
    wait_done(1'b0, c0, "t5_done");
    check("t5_err", error_a, 1'b1);
    check("t5_access_cyc", acc_tot_a - a0, 8);
    check("t5_psel", bus_a.psel, 1'b0);
    hold_low = 1'b0;
    got_a.delete(); c0 = done_cnt_a;
    pulse_start(1'b0, 32'h120, 1);
    wait_done(1'b0, c0, "t5b_done");
    check("t5b_err", error_a, 1'b0);
    expect_chars("t5b", got_a, "abcd");

    // Illegal word counts: no APB traffic, error and done
    addr_a.delete(); c0 = done_cnt_a;
    pulse_start(1'b0, C_PLATFORM_NAME00, 0);
    wait_done(1'b0, c0, "t6_done");
    check("t6_err", error_a, 1'b1);
    check("t6_no_apb", addr_a.size(), 0);
    c0 = done_cnt_a;
    pulse_start(1'b0, C_PLATFORM_NAME00, 17);
    wait_done(1'b0, c0, "t6b_done");
    check("t6b_err", error_a, 1'b1);
    check("t6b_no_apb", addr_a.size(), 0);

    // Reset while a character is being held
    ready_low = 1'b1;
    pulse_start(1'b0, 32'h120, 2);
    n0 = 0;
    while (!bus_a.char_valid && n0 < 20) begin @(negedge clk); n0++; end
    check("t7_valid_seen", bus_a.char_valid, 1'b1);
    #2 rstnn = 1'b0;
    #1 check_zero_a("t7_rst");
    @(negedge clk);
    rstnn = 1'b1;
    ready_low = 1'b0;
    n0 = got_a.size();
    repeat (10) @(negedge clk);
    check("t7_no_emit", got_a.size() - n0, 0);
    check("t7_idle", {busy_a, bus_a.psel, bus_a.char_valid}, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
